// File: rtl/patch_sequencer_pkg.sv
// Shared constants and types for the patch sequencer: config map, slot
// register offsets and the two-state play FSM encoding.
package patch_pkg;
  localparam logic [15:0] SLOT_BASE   = 16'h7000;
  localparam logic [15:0] RAM_BASE    = 16'h7100;
  localparam logic [1:0]  REG_TRIG_LO = 2'd0;
  localparam logic [1:0]  REG_TRIG_HI = 2'd1;
  localparam logic [1:0]  REG_OFFSET  = 2'd2;
  localparam logic [1:0]  REG_LENGTH  = 2'd3;
  localparam int          MAX_SLOTS   = 8;

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_e;
endpackage

// File: rtl/patch_sequencer_if.sv
// Config, burst-watch and read-override signals of the patch sequencer.
interface patch_sequencer_if;
  logic [15:0] config_addr;
  logic [15:0] config_data;
  logic        config_strobe;
  logic [22:0] burst_addr;
  logic        burst_addr_strobe;
  logic        patch_trigger;
  logic        patch_active;
  logic [2:0]  patch_slot;
  logic [15:0] patch_data;
  logic        patch_data_next;
  logic [15:0] patch_count;

  modport master (output config_addr, config_data, config_strobe, burst_addr,
                         burst_addr_strobe, patch_data_next,
                  input  patch_trigger, patch_active, patch_slot, patch_data,
                         patch_count);
  modport slave  (input  config_addr, config_data, config_strobe, burst_addr,
                         burst_addr_strobe, patch_data_next,
                  output patch_trigger, patch_active, patch_slot, patch_data,
                         patch_count);
endinterface

// File: rtl/patch_sequencer_ram.sv
// Patch-data RAM: one config write port, one synchronous read-first read
// port whose output holds until the next enabled read.
module patch_ram #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   rdata
);
  logic [15:0] mem [2**AW];
  logic [15:0] rdata_q, rdata_d;

  // Only load a new word when asked, so a displayed word is never disturbed
  always_comb rdata_d = re ? mem[raddr] : rdata_q;

  // Write and read share the edge; the read sees the pre-write contents
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/patch_sequencer.sv
// Programmable patch sequencer: slot table, priority trigger match and the
// IDLE/ACTIVE play FSM feeding fake read words from the patch RAM.
module patch_sequencer
  import patch_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int RAM_AW    = 8
) (
  input logic           mclk,
  input logic           reset,
  patch_sequencer_if.slave bus
);
  localparam logic [15:0] SLOT_SPAN = 16'(4 * NUM_SLOTS);
  localparam logic [15:0] RAM_SPAN  = 16'(1 << RAM_AW);
  localparam logic [RAM_AW:0] LEN_ONE = {{RAM_AW{1'b0}}, 1'b1};

  logic [NUM_SLOTS-1:0][15:0]       trig_lo_q, trig_lo_d;
  logic [NUM_SLOTS-1:0][6:0]        trig_hi_q, trig_hi_d;
  logic [NUM_SLOTS-1:0]             en_q, en_d;
  logic [NUM_SLOTS-1:0][RAM_AW-1:0] offset_q, offset_d;
  logic [NUM_SLOTS-1:0][RAM_AW:0]   length_q, length_d;

  state_e            state_q, state_d;
  logic [RAM_AW-1:0] ptr_q, ptr_d;
  logic [RAM_AW:0]   rem_q, rem_d;
  logic [2:0]        slot_q, slot_d;
  logic [15:0]       count_q, count_d;

  logic [15:0]       slot_off, ram_off;
  logic              slot_we, ram_we;
  logic              hit;
  logic [2:0]        win_idx;
  logic [RAM_AW-1:0] win_off;
  logic [RAM_AW:0]   win_len;
  logic              rd_en;
  logic [RAM_AW-1:0] rd_addr;
  logic [15:0]       rd_data;

  // Config address decode; addresses below a base wrap high and miss
  always_comb begin
    slot_off = bus.config_addr - SLOT_BASE;
    ram_off  = bus.config_addr - RAM_BASE;
    slot_we  = bus.config_strobe && (slot_off < SLOT_SPAN);
    ram_we   = bus.config_strobe && (ram_off < RAM_SPAN);
  end

  // Slot register writes
  always_comb begin
    trig_lo_d = trig_lo_q;
    trig_hi_d = trig_hi_q;
    en_d      = en_q;
    offset_d  = offset_q;
    length_d  = length_q;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (slot_we && slot_off[4:2] == 3'(s)) begin
        case (slot_off[1:0])
          REG_TRIG_LO: trig_lo_d[s] = bus.config_data;
          REG_TRIG_HI: begin
            trig_hi_d[s] = bus.config_data[6:0];
            en_d[s]      = bus.config_data[15];
          end
          REG_OFFSET:  offset_d[s] = bus.config_data[RAM_AW-1:0];
          default:     length_d[s] = bus.config_data[RAM_AW:0];
        endcase
      end
    end
  end

  // Priority match: scan high to low so the lowest matching slot wins
  always_comb begin
    hit     = 1'b0;
    win_idx = '0;
    win_off = '0;
    win_len = '0;
    for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
      if (bus.burst_addr_strobe && en_q[s] && length_q[s] != '0 &&
          {trig_hi_q[s], trig_lo_q[s]} == bus.burst_addr) begin
        hit     = 1'b1;
        win_idx = 3'(s);
        win_off = offset_q[s];
        win_len = length_q[s];
      end
    end
  end

  // Next state and sequence pointer; a strobe overrides a same-cycle advance
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    slot_d  = slot_q;
    rd_en   = 1'b0;
    rd_addr = ptr_q;
    if (hit) begin
      state_d = ACTIVE;
      ptr_d   = win_off;
      rem_d   = win_len;
      slot_d  = win_idx;
      rd_en   = 1'b1;
      rd_addr = win_off;
    end else if (state_q == ACTIVE) begin
      if (bus.burst_addr_strobe) begin
        state_d = IDLE;
      end else if (bus.patch_data_next) begin
        if (rem_q == LEN_ONE) begin
          state_d = IDLE;
        end else begin
          ptr_d   = ptr_q + 1'b1;
          rem_d   = rem_q - 1'b1;
          rd_en   = 1'b1;
          rd_addr = ptr_q + 1'b1;
        end
      end
    end
    count_d = (hit && count_q != 16'hFFFF) ? count_q + 16'd1 : count_q;
  end

  // State, sequence and slot-table registers
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      rem_q     <= '0;
      slot_q    <= '0;
      count_q   <= '0;
      trig_lo_q <= '0;
      trig_hi_q <= '0;
      en_q      <= '0;
      offset_q  <= '0;
      length_q  <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      rem_q     <= rem_d;
      slot_q    <= slot_d;
      count_q   <= count_d;
      trig_lo_q <= trig_lo_d;
      trig_hi_q <= trig_hi_d;
      en_q      <= en_d;
      offset_q  <= offset_d;
      length_q  <= length_d;
    end
  end

  patch_ram #(.AW(RAM_AW)) u_ram (
    .clk   (mclk),
    .we    (ram_we),
    .waddr (ram_off[RAM_AW-1:0]),
    .wdata (bus.config_data),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // Outputs; data is gated so idle (and reset) always shows zero
  always_comb begin
    bus.patch_trigger = hit;
    bus.patch_active  = (state_q == ACTIVE);
    bus.patch_slot    = slot_q;
    bus.patch_data    = (state_q == ACTIVE) ? rd_data : 16'h0000;
    bus.patch_count   = count_q;
  end
endmodule

// File: tb/tb_patch_sequencer.sv
// Directed bench for patch_sequencer with a queue-based reference model.
module tb_patch_sequencer;
  logic mclk = 1'b0;
  logic reset = 1'b1;
  patch_sequencer_if bus();

  patch_sequencer #(.NUM_SLOTS(4), .RAM_AW(8)) dut (
    .mclk  (mclk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 mclk = ~mclk;

  int checks = 0;
  int failures = 0;
  bit run = 1'b0;

  // Reference model: slot table, RAM image, and the list of addresses still to play
  logic [15:0] sl_lo [4];
  logic [6:0]  sl_hi [4];
  logic        sl_en [4];
  logic [7:0]  sl_off [4];
  logic [8:0]  sl_len [4];
  logic [15:0] m_ram [256];
  logic        m_active = 1'b0;
  logic [2:0]  m_slot = 3'd0;
  logic [15:0] m_word = 16'h0;
  logic [15:0] m_count = 16'h0;
  int          m_q[$];

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, a, e, $time);
    end
  endtask

  function automatic int match_slot();
    if (!bus.burst_addr_strobe) return -1;
    for (int s = 0; s < 4; s++)
      if (sl_en[s] && sl_len[s] != 0 && {sl_hi[s], sl_lo[s]} == bus.burst_addr)
        return s;
    return -1;
  endfunction

  initial begin
    for (int s = 0; s < 4; s++) begin
      sl_lo[s] = 0; sl_hi[s] = 0; sl_en[s] = 0; sl_off[s] = 0; sl_len[s] = 0;
    end
    for (int n = 0; n < 256; n++) m_ram[n] = 16'h0;
  end

  always @(posedge mclk or posedge reset) begin
    int w;
    int ca;
    if (reset) begin
      m_active = 1'b0; m_slot = 3'd0; m_count = 16'h0; m_q.delete();
      for (int s = 0; s < 4; s++) begin
        sl_lo[s] = 0; sl_hi[s] = 0; sl_en[s] = 0; sl_off[s] = 0; sl_len[s] = 0;
      end
    end else begin
      w = match_slot();
      if (w >= 0) begin
        m_active = 1'b1;
        m_slot = 3'(w);
        m_q.delete();
        for (int i = 0; i < int'(sl_len[w]); i++) m_q.push_back((int'(sl_off[w]) + i) % 256);
        m_word = m_ram[m_q[0]];
        if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
      end else if (m_active && bus.burst_addr_strobe) begin
        m_active = 1'b0;
      end else if (m_active && bus.patch_data_next) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) m_active = 1'b0;
        else m_word = m_ram[m_q[0]];
      end
      if (bus.config_strobe) begin
        ca = int'(bus.config_addr);
        if (ca >= 'h7000 && ca < 'h7010) begin
          case ((ca - 'h7000) % 4)
            0: sl_lo[(ca - 'h7000) / 4] = bus.config_data;
            1: begin
              sl_hi[(ca - 'h7000) / 4] = bus.config_data[6:0];
              sl_en[(ca - 'h7000) / 4] = bus.config_data[15];
            end
            2: sl_off[(ca - 'h7000) / 4] = bus.config_data[7:0];
            default: sl_len[(ca - 'h7000) / 4] = bus.config_data[8:0];
          endcase
        end else if (ca >= 'h7100 && ca < 'h7200) begin
          m_ram[ca - 'h7100] = bus.config_data;
        end
      end
    end
  end

  // Per-cycle compare, mid-cycle after the driver has settled the inputs
  always @(negedge mclk) begin
    #2;
    if (run) begin
      chk("trigger", 32'(bus.patch_trigger), 32'(match_slot() >= 0));
      chk("active", 32'(bus.patch_active), 32'(m_active));
      chk("data", 32'(bus.patch_data), m_active ? 32'(m_word) : 32'h0);
      chk("count", 32'(bus.patch_count), 32'(m_count));
      if (m_active) chk("slot", 32'(bus.patch_slot), 32'(m_slot));
    end
  end

  task automatic drive(logic cs, logic [15:0] ca, logic [15:0] cd,
                       logic bs, logic [22:0] ba, logic nx);
    @(negedge mclk);
    bus.config_strobe = cs; bus.config_addr = ca; bus.config_data = cd;
    bus.burst_addr_strobe = bs; bus.burst_addr = ba; bus.patch_data_next = nx;
  endtask
  task automatic cfg(logic [15:0] a, logic [15:0] d); drive(1'b1, a, d, 1'b0, 23'h0, 1'b0); endtask
  task automatic strobe(logic [22:0] a); drive(1'b0, 16'h0, 16'h0, 1'b1, a, 1'b0); endtask
  task automatic nxt(); drive(1'b0, 16'h0, 16'h0, 1'b0, 23'h0, 1'b1); endtask
  task automatic idle(); drive(1'b0, 16'h0, 16'h0, 1'b0, 23'h0, 1'b0); endtask
  task automatic prog(int s, logic [22:0] t, logic [7:0] off, logic [8:0] len);
    cfg(16'(16'h7000 + 4 * s), t[15:0]);
    cfg(16'(16'h7001 + 4 * s), {9'h100, t[22:16]});
    cfg(16'(16'h7002 + 4 * s), {8'h0, off});
    cfg(16'(16'h7003 + 4 * s), {7'h0, len});
  endtask

  initial begin
    bus.config_strobe = 0; bus.config_addr = 0; bus.config_data = 0;
    bus.burst_addr_strobe = 0; bus.burst_addr = 0; bus.patch_data_next = 0;
    repeat (2) @(negedge mclk);
    #3;
    chk("rst_active", 32'(bus.patch_active), 0);
    chk("rst_slot", 32'(bus.patch_slot), 0);
    chk("rst_data", 32'(bus.patch_data), 0);
    chk("rst_count", 32'(bus.patch_count), 0);
    @(negedge mclk); reset = 1'b0; run = 1'b1;

    // RAM image and slot programming
    cfg(16'h7100, 16'h1111); cfg(16'h7101, 16'h2222); cfg(16'h7102, 16'h3333);
    cfg(16'h7110, 16'hAAAA); cfg(16'h7111, 16'hAAAB); cfg(16'h7120, 16'hBBBB);
    cfg(16'h71FE, 16'hFE00); cfg(16'h71FF, 16'hFF00);
    cfg(16'h7200, 16'hDEAD); cfg(16'h70FF, 16'hDEAD);
    prog(0, 23'h7f70f0, 8'h00, 9'd3);
    prog(1, 23'h000123, 8'h10, 9'd2);
    prog(2, 23'h000123, 8'h20, 9'd1);
    prog(3, 23'h000456, 8'hFE, 9'd4);

    // Single slot, three words
    strobe(23'h7f70f0); #3 chk("t1_trig", 32'(bus.patch_trigger), 1);
    nxt(); #3 chk("t1_w0", 32'(bus.patch_data), 32'h1111);
    nxt(); #3 chk("t1_w1", 32'(bus.patch_data), 32'h2222);
    nxt(); #3 chk("t1_w2", 32'(bus.patch_data), 32'h3333);
    idle(); #3 chk("t1_done_act", 32'(bus.patch_active), 0);
    chk("t1_done_data", 32'(bus.patch_data), 0);
    nxt();

    // Priority between slots 1 and 2
    strobe(23'h000123);
    nxt(); #3 chk("pri_slot", 32'(bus.patch_slot), 1);
    chk("pri_w0", 32'(bus.patch_data), 32'hAAAA);
    nxt(); #3 chk("pri_w1", 32'(bus.patch_data), 32'hAAAB);
    cfg(16'h7005, 16'h0000);
    strobe(23'h000123);
    idle(); #3 chk("pri2_slot", 32'(bus.patch_slot), 2);
    chk("pri2_w0", 32'(bus.patch_data), 32'hBBBB);

    // Abort, then restart with a simultaneous next
    strobe(23'h000555);
    idle(); #3 chk("abort", 32'(bus.patch_active), 0);
    strobe(23'h7f70f0);
    nxt();
    drive(1'b0, 16'h0, 16'h0, 1'b1, 23'h7f70f0, 1'b1);
    idle(); #3 chk("restart_w0", 32'(bus.patch_data), 32'h1111);
    strobe(23'h000999);

    // Wrap across the RAM end, then length zero
    strobe(23'h000456);
    nxt(); #3 chk("wrap_fe", 32'(bus.patch_data), 32'hFE00);
    nxt(); #3 chk("wrap_ff", 32'(bus.patch_data), 32'hFF00);
    nxt(); #3 chk("wrap_00", 32'(bus.patch_data), 32'h1111);
    nxt(); #3 chk("wrap_01", 32'(bus.patch_data), 32'h2222);
    idle(); #3 chk("wrap_done", 32'(bus.patch_active), 0);
    cfg(16'h700F, 16'h0000);
    strobe(23'h000456); #3 chk("len0_trig", 32'(bus.patch_trigger), 0);

    // Read-first RAM hazard, replay sees new value
    drive(1'b1, 16'h7100, 16'h5555, 1'b1, 23'h7f70f0, 1'b0);
    idle(); #3 chk("rf_old", 32'(bus.patch_data), 32'h1111);
    strobe(23'h000999);
    strobe(23'h7f70f0);
    idle(); #3 chk("rf_new", 32'(bus.patch_data), 32'h5555);

    // Length rewrite while active keeps the latched length
    cfg(16'h7003, 16'h0001);
    nxt(); nxt(); #3 chk("len_keep_w1", 32'(bus.patch_data), 32'h2222);
    nxt(); #3 chk("len_keep_w2", 32'(bus.patch_data), 32'h3333);
    idle();

    // Reset mid-sequence
    strobe(23'h7f70f0);
    idle();
    @(negedge mclk); reset = 1'b1; bus.burst_addr_strobe = 0;
    #3 chk("mrst_active", 32'(bus.patch_active), 0);
    chk("mrst_data", 32'(bus.patch_data), 0);
    chk("mrst_count", 32'(bus.patch_count), 0);
    @(negedge mclk); reset = 1'b0;
    strobe(23'h7f70f0); #3 chk("mrst_slots_clear", 32'(bus.patch_trigger), 0);

    // Counter saturation from a preloaded value
    prog(0, 23'h7f70f0, 8'h00, 9'd1);
    @(negedge mclk);
    force dut.count_q = 16'hFFFD;
    m_count = 16'hFFFD;
    #1 release dut.count_q;
    repeat (4) strobe(23'h7f70f0);
    idle(); #3 chk("sat", 32'(bus.patch_count), 32'hFFFF);
    idle();

    run = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
